// File: rtl/mfp_spi_tx_scheduler.sv
// mfp_spi_tx_scheduler
// Round-robin scheduler sharing one SPI transmit link among N_REQ requesters.
// Grants one requester at a time, holds spi_start until the (asynchronous)
// spi_stop edge is seen, then enforces an inter-frame gap of GAP_CYCLES.
// Optional watchdog: define SPI_TX_SCHED_TIMEOUT_EN to abort a frame that sees
// no stop within TIMEOUT_CYCLES and raise the sticky timeout_err flag.
module mfp_spi_tx_scheduler #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 16,
    parameter int GAP_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant_ack,
    output logic                    spi_start,
    output logic [DATA_W-1:0]       spi_data,
    input  logic                    spi_stop,
    output logic                    busy,
    output logic [2:0]              last_grant,
    output logic                    timeout_err,
    input  logic                    err_clr
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int IDX_W = $clog2(N_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    // With no gap configured a finished frame returns straight to IDLE.
    localparam logic [1:0] ST_AFTER_SEND = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    logic [1:0]        state;
    logic [GAP_W-1:0]  gap_cnt;
    logic              stop_meta;
    logic              stop_sync;
    logic              stop_prev;
    logic              stop_rise;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [3:0]        cand_sum;
    logic              frame_abort;
    logic [DATA_W-1:0] words [N_REQ];

    // Unpack the flat request data bus into per-requester words.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
        assign words[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // Two-flop synchronizer for spi_stop plus a delay stage for edge detection.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            stop_meta <= 1'b0;
            stop_sync <= 1'b0;
            stop_prev <= 1'b0;
        end else begin
            stop_meta <= spi_stop;
            stop_sync <= stop_meta;
            stop_prev <= stop_sync;
        end
    end

    assign stop_rise = stop_sync & ~stop_prev;

    // Round-robin pick: first set request strictly after last_grant, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_sum = {1'b0, last_grant} + 4'(k);
            if (cand_sum >= 4'(N_REQ)) begin
                cand_sum = cand_sum - 4'(N_REQ);
            end
            if (!win_found && req[cand_sum[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_sum[IDX_W-1:0];
            end
        end
    end

`ifdef SPI_TX_SCHED_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            unused_cfg;

    // A real stop edge in the same cycle takes priority over the watchdog.
    assign frame_abort = (state == ST_SEND) && !stop_rise && (wd_cnt == WD_LAST);
    assign unused_cfg  = 1'b0;

    // Watchdog counts SEND cycles; it restarts from zero on every frame.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wd_cnt <= '0;
        end else if (state != ST_SEND) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_LAST) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Sticky abort flag; a new abort wins over a simultaneous clear.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            timeout_err <= 1'b0;
        end else if (frame_abort) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign frame_abort = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_cfg  = err_clr ^ (TIMEOUT_CYCLES > 0);
`endif

    // Main IDLE -> SEND -> GAP sequencer driving the spi_master handshake.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            grant_ack  <= '0;
            spi_start  <= 1'b0;
            spi_data   <= '0;
            last_grant <= 3'(N_REQ - 1);
        end else begin
            grant_ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        spi_data           <= words[win_idx];
                        spi_start          <= 1'b1;
                        grant_ack[win_idx] <= 1'b1;
                        last_grant         <= 3'(win_idx);
                        state              <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (stop_rise || frame_abort) begin
                        spi_start <= 1'b0;
                        gap_cnt   <= GAP_LOAD;
                        state     <= ST_AFTER_SEND;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mfp_spi_tx_scheduler.sv
// tb_mfp_spi_tx_scheduler
// Self-checking bench for mfp_spi_tx_scheduler. Directed scenarios plus a
// randomized run checked against a round-robin / timing reference model.
// Honours SPI_TX_SCHED_TIMEOUT_EN for the watchdog scenario.
module tb_mfp_spi_tx_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int G  = 5;
    localparam int TO = 100;

    logic            HCLK;
    logic            HRESET;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant_ack;
    logic            spi_start;
    logic [DW-1:0]   spi_data;
    logic            spi_stop;
    logic            busy;
    logic [2:0]      last_grant;
    logic            timeout_err;
    logic            err_clr;

    int vectors;
    int miscompares;
    int model_last;

    mfp_spi_tx_scheduler #(
        .N_REQ(N),
        .DATA_W(DW),
        .GAP_CYCLES(G),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .req(req),
        .req_data(req_data),
        .grant_ack(grant_ack),
        .spi_start(spi_start),
        .spi_data(spi_data),
        .spi_stop(spi_stop),
        .busy(busy),
        .last_grant(last_grant),
        .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Round-robin rule: first set bit after 'last', wrapping modulo N.
    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] word_of(input int i);
        return req_data[i*DW +: DW];
    endfunction

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset;
        HRESET   = 1'b1;
        req      = '0;
        spi_stop = 1'b0;
        err_clr  = 1'b0;
        repeat (2) tick;
        HRESET = 1'b0;
        tick;
        model_last = N - 1;
    endtask

    // Raise stop and count cycles until spi_start drops (-1 if it never does).
    task automatic close_frame(output int n);
        spi_stop = 1'b1;
        n = 0;
        while (spi_start === 1'b1 && n < 20) begin
            tick;
            n++;
        end
        spi_stop = 1'b0;
        if (spi_start === 1'b1) n = -1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        HRESET   = 1'b1;
        req      = '0;
        spi_stop = 1'b0;
        err_clr  = 1'b0;
        req_data = {$urandom, $urandom};
        repeat (2) tick;
        vectors++;
        if (grant_ack !== '0 || spi_start !== 1'b0 || spi_data !== '0 || busy !== 1'b0 ||
            last_grant !== 3'd3 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: ack=%b start=%b data=%h busy=%b last=%0d terr=%b, expected 0 0 0000 0 3 0",
                     grant_ack, spi_start, spi_data, busy, last_grant, timeout_err);
        end
        HRESET = 1'b0;
        repeat (3) tick;
        vectors++;
        if (busy !== 1'b0 || spi_start !== 1'b0 || grant_ack !== '0) begin
            miscompares++;
            $display("FAIL reset_idle_no_req: busy=%b start=%b ack=%b, expected all 0", busy, spi_start, grant_ack);
        end
        model_last = N - 1;
    endtask

    task automatic test_single;
        int n;
        do_reset;
        req_data[0 +: DW] = 16'h00A5;
        req = 4'b0001;
        tick;
        vectors++;
        if (grant_ack !== 4'b0001 || spi_start !== 1'b1 || spi_data !== 16'h00A5 ||
            last_grant !== 3'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant: ack=%b start=%b data=%h last=%0d busy=%b, expected 0001 1 00a5 0 1",
                     grant_ack, spi_start, spi_data, last_grant, busy);
        end
        req = '0;
        repeat (3) tick;
        vectors++;
        if (spi_start !== 1'b1 || grant_ack !== '0 || spi_data !== 16'h00A5) begin
            miscompares++;
            $display("FAIL single_hold: start=%b ack=%b data=%h, expected 1 0000 00a5", spi_start, grant_ack, spi_data);
        end
        close_frame(n);
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL single_stop_latency: got %0d cycles, expected 3", n);
        end
        wait_idle(n);
        vectors++;
        if (n != G) begin
            miscompares++;
            $display("FAIL single_gap_length: busy for %0d cycles after stop, expected %0d", n, G);
        end
    endtask

    task automatic test_round_robin;
        int n;
        int w;
        logic [N-1:0] em;
        do_reset;
        req_data = {$urandom, $urandom};
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            n = 0;
            while (grant_ack === '0 && n < 60) begin
                tick;
                n++;
            end
            w  = rr_pick(req, model_last);
            em = 4'b0001 << w;
            vectors++;
            if (grant_ack !== em || spi_data !== word_of(w) || last_grant !== 3'(w) || spi_start !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: ack=%b data=%h last=%0d start=%b, expected %b %h %0d 1",
                         f, grant_ack, spi_data, last_grant, spi_start, em, word_of(w), w);
            end
            if (f > 0) begin
                vectors++;
                if (n != G + 1) begin
                    miscompares++;
                    $display("FAIL rr_spacing_%0d: start low %0d cycles, expected %0d", f, n, G + 1);
                end
            end
            model_last = w;
            repeat ($urandom_range(1, 5)) tick;
            close_frame(n);
            vectors++;
            if (n != 3) begin
                miscompares++;
                $display("FAIL rr_stop_%0d: got %0d cycles, expected 3", f, n);
            end
        end
        req = '0;
        wait_idle(n);
    endtask

    task automatic test_late_request;
        int n;
        int bad;
        do_reset;
        req_data = {$urandom, $urandom};
        req = 4'b0001;
        tick;
        req = '0;
        tick;
        req = 4'b0100;
        bad = 0;
        repeat (4) begin
            tick;
            if (grant_ack !== '0) bad++;
        end
        close_frame(n);
        n = 0;
        while (grant_ack === '0 && n < 60) begin
            tick;
            n++;
        end
        vectors++;
        if (bad != 0 || n != G + 1 || grant_ack !== 4'b0100 || last_grant !== 3'd2 || spi_data !== word_of(2)) begin
            miscompares++;
            $display("FAIL late_request: early_acks=%0d wait=%0d ack=%b last=%0d data=%h, expected 0 %0d 0100 2 %h",
                     bad, n, grant_ack, last_grant, spi_data, G + 1, word_of(2));
        end
        req = '0;
        close_frame(n);
        wait_idle(n);
    endtask

    task automatic test_stop_held;
        int n;
        do_reset;
        spi_stop = 1'b1;
        repeat (4) tick;
        req = 4'b0001;
        tick;
        req = '0;
        vectors++;
        if (grant_ack !== 4'b0001 || spi_start !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_held_grant: ack=%b start=%b, expected 0001 1", grant_ack, spi_start);
        end
        repeat (10) tick;
        vectors++;
        if (spi_start !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_held_ignored: start=%b busy=%b, expected 1 1", spi_start, busy);
        end
        spi_stop = 1'b0;
        repeat (3) tick;
        vectors++;
        if (spi_start !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_fall_ignored: start=%b, expected 1", spi_start);
        end
        close_frame(n);
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL stop_rearm: got %0d cycles, expected 3", n);
        end
        wait_idle(n);
    endtask

    task automatic test_reset_mid_send;
        int n;
        do_reset;
        req_data = {$urandom, $urandom};
        req = 4'b0001;
        tick;
        req = '0;
        repeat (3) tick;
        #2;
        HRESET = 1'b1;
        #1;
        vectors++;
        if (spi_start !== 1'b0 || busy !== 1'b0 || last_grant !== 3'd3 || grant_ack !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_send: start=%b busy=%b last=%0d ack=%b, expected 0 0 3 0000",
                     spi_start, busy, last_grant, grant_ack);
        end
        tick;
        HRESET = 1'b0;
        model_last = N - 1;
        req = 4'b0010;
        tick;
        req = '0;
        vectors++;
        if (grant_ack !== 4'b0010 || last_grant !== 3'd1 || spi_start !== 1'b1 || spi_data !== word_of(1)) begin
            miscompares++;
            $display("FAIL post_reset_grant: ack=%b last=%0d start=%b data=%h, expected 0010 1 1 %h",
                     grant_ack, last_grant, spi_start, spi_data, word_of(1));
        end
        close_frame(n);
        wait_idle(n);
    endtask

    task automatic test_timeout;
        int n;
        do_reset;
        req = 4'b0001;
        tick;
        req = '0;
        n = 0;
        while (spi_start === 1'b1 && n < 150) begin
            tick;
            n++;
        end
`ifdef SPI_TX_SCHED_TIMEOUT_EN
        vectors++;
        if (n != TO || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_abort: start high %0d cycles terr=%b, expected %0d 1", n, timeout_err, TO);
        end
        repeat (3) tick;
        vectors++;
        if (timeout_err !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: terr=%b busy=%b, expected 1 1", timeout_err, busy);
        end
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: terr=%b, expected 0", timeout_err);
        end
        wait_idle(n);
        err_clr = 1'b1;
        req = 4'b0001;
        tick;
        req = '0;
        n = 0;
        while (spi_start === 1'b1 && n < 150) begin
            tick;
            n++;
        end
        vectors++;
        if (n != TO || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_set_wins: cycles=%0d terr=%b, expected %0d 1", n, timeout_err, TO);
        end
        tick;
        err_clr = 1'b0;
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear2: terr=%b, expected 0", timeout_err);
        end
        wait_idle(n);
`else
        vectors++;
        if (n != 150 || timeout_err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL no_watchdog: start high %0d cycles terr=%b busy=%b, expected 150 0 1", n, timeout_err, busy);
        end
        close_frame(n);
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL no_watchdog_stop: got %0d cycles, expected 3", n);
        end
        wait_idle(n);
`endif
    endtask

    // Randomized requests/stops against the round-robin + gap timing model.
    task automatic test_random;
        logic [N-1:0] req_prev;
        logic [N-1:0] em;
        int c, in_send, free_at, fall_due, stop_cnt, hold, grants, gw, b;
        logic exp_busy;
        do_reset;
        c = 0; in_send = 0; free_at = 0; fall_due = -1;
        stop_cnt = 0; hold = 0; grants = 0;
        for (int it = 0; it < 1500; it++) begin
            req_prev = req;
            tick;
            c++;
            gw = -1;
            if (in_send != 0) begin
                if (c == fall_due) begin
                    vectors++;
                    if (spi_start !== 1'b0 || grant_ack !== '0) begin
                        miscompares++;
                        $display("FAIL rand_fall c=%0d: start=%b ack=%b, expected 0 0000", c, spi_start, grant_ack);
                    end
                    in_send = 0;
                    fall_due = -1;
                    free_at = c + G + 1;
                end else begin
                    vectors++;
                    if (spi_start !== 1'b1 || grant_ack !== '0) begin
                        miscompares++;
                        $display("FAIL rand_send c=%0d: start=%b ack=%b, expected 1 0000", c, spi_start, grant_ack);
                    end
                end
            end else if (c >= free_at && req_prev != '0) begin
                gw = rr_pick(req_prev, model_last);
                em = 4'b0001 << gw;
                vectors++;
                if (grant_ack !== em || spi_start !== 1'b1 || spi_data !== word_of(gw) || last_grant !== 3'(gw)) begin
                    miscompares++;
                    $display("FAIL rand_grant c=%0d: ack=%b start=%b data=%h last=%0d, expected %b 1 %h %0d",
                             c, grant_ack, spi_start, spi_data, last_grant, em, word_of(gw), gw);
                end
                model_last = gw;
                in_send = 1;
                stop_cnt = $urandom_range(1, 6);
                grants++;
                req[gw] = 1'b0;
            end else begin
                vectors++;
                if (grant_ack !== '0 || spi_start !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_idle c=%0d: ack=%b start=%b, expected 0000 0", c, grant_ack, spi_start);
                end
            end
            exp_busy = (in_send != 0) || (c < free_at - 1);
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL rand_busy c=%0d: busy=%b, expected %b", c, busy, exp_busy);
            end
            if (hold > 0) begin
                hold--;
                if (hold == 0) spi_stop = 1'b0;
            end
            if (in_send != 0 && fall_due < 0) begin
                stop_cnt--;
                if (stop_cnt == 0) begin
                    spi_stop = 1'b1;
                    hold = 2;
                    fall_due = c + 3;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                b = $urandom_range(0, N - 1);
                if (!req[b] && b != gw) begin
                    req_data[b*DW +: DW] = DW'($urandom);
                    req[b] = 1'b1;
                end
            end
        end
        vectors++;
        if (grants < 20) begin
            miscompares++;
            $display("FAIL rand_progress: %0d grants, expected at least 20", grants);
        end
        req = '0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_last = N - 1;
        test_reset;
        test_single;
        test_round_robin;
        test_late_request;
        test_stop_held;
        test_reset_mid_send;
        test_timeout;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
